fifo_wr_arbiter: RTL

Round-robin write arbiter that shares the single 8-bit-wide FIFO write port (`wr_en`/`data_in`, gated by `full`) among several producers. Each producer presents data on a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst, steers that producer's data onto the FIFO write port, and stalls on `full`. It sits directly in front of the FIFO on the write side; the read side is untouched.

---
 rtl/fifo_wr_arbiter_if.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 101 ++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between producers, the round-robin arbiter and the FIFO write port.
// The master modport is the arbiter's view; slave is the producer/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned DataW  = 8
);
  localparam int unsigned IdW = $clog2(NumReq);

  logic [NumReq-1:0]       req_valid;
  logic [NumReq*DataW-1:0] req_data;
  logic [NumReq-1:0]       req_ready;
  logic                    fifo_full;
  logic                    fifo_wr_en;
  logic [DataW-1:0]        fifo_data_in;
  logic                    grant_valid;
  logic [IdW-1:0]          grant_id;
  logic [15:0]             wr_count;

  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id, wr_count
  );

  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id, wr_count
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NumReq valid/ready producers,
// with bounded bursts per grant and a free-running 16-bit write counter.
module fifo_wr_arbiter #(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned DataW    = 8,
  parameter int unsigned MaxBurst = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  fifo_wr_arbiter_if.master     bus
);
  localparam int unsigned IdW = $clog2(NumReq);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e            state_q, state_d;
  logic [IdW-1:0]    grant_id_q, grant_id_d;
  logic [IdW-1:0]    last_id_q, last_id_d;
  logic [3:0]        burst_cnt_q, burst_cnt_d;
  logic [15:0]       wr_count_q, wr_count_d;

  logic              grant_valid;
  logic              accept;
  logic              pick_found;
  logic [IdW-1:0]    pick_id;
  logic [IdW-1:0]    scan_id;
  logic [NumReq-1:0] req_ready;

  assign grant_valid = (state_q == StGrant);
  assign accept      = grant_valid & bus.req_valid[grant_id_q] & ~bus.fifo_full;

  // First requester searching upward from the producer after the last owner.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan_id    = '0;
    for (int unsigned k = 1; k <= NumReq; k++) begin
      scan_id = IdW'((32'(last_id_q) + k) % NumReq);
      if (!pick_found && bus.req_valid[scan_id]) begin
        pick_found = 1'b1;
        pick_id    = scan_id;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    last_id_d   = last_id_q;
    burst_cnt_d = burst_cnt_q;
    wr_count_d  = accept ? wr_count_q + 16'd1 : wr_count_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d     = StGrant;
          grant_id_d  = pick_id;
          burst_cnt_d = '0;
        end
      end
      StGrant: begin
        if (accept) begin
          burst_cnt_d = burst_cnt_q + 4'd1;
        end
        // Burst limit and a valid drop in the same cycle collapse into one release.
        if ((accept && (burst_cnt_q == 4'(MaxBurst - 1))) || !bus.req_valid[grant_id_q]) begin
          state_d   = StIdle;
          last_id_d = grant_id_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      grant_id_q  <= '0;
      last_id_q   <= IdW'(NumReq - 1);
      burst_cnt_q <= '0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      last_id_q   <= last_id_d;
      burst_cnt_q <= burst_cnt_d;
      wr_count_q  <= wr_count_d;
    end
  end

  always_comb begin
    req_ready             = '0;
    req_ready[grant_id_q] = accept;
  end

  assign bus.req_ready    = req_ready;
  assign bus.fifo_wr_en   = accept;
  assign bus.fifo_data_in = grant_valid ? bus.req_data[32'(grant_id_q) * DataW +: DataW] : '0;
  assign bus.grant_valid  = grant_valid;
  assign bus.grant_id     = grant_id_q;
  assign bus.wr_count     = wr_count_q;
endmodule
